// File: rtl/vreg_rd_arbiter.sv
// vreg_rd_arbiter: round-robin arbiter and sequencer for the shared read port
// of the V16..V23 vector-register mux. A single grant per cycle drives the mux
// select, and the returned vector is captured into a response register that is
// handed to the consumer with a valid/ready handshake tagged by requester ID.
module vreg_rd_arbiter #(
    parameter int N   = 4,
    parameter int I   = 20,
    parameter int L   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    input  logic [N*5-1:0]     req_addr,
    output logic [N-1:0]       req_ready,
    output logic [4:0]         rf_sel,
    input  logic [I*L-1:0]     rf_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_err,
    output logic [I*L-1:0]     rsp_data
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Round-robin pick: returns {found, index} of the first valid requester
    // scanning p, p+1, ... mod N. Scanning from the far end lets the nearest
    // valid requester overwrite the result last.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] v,
                                             input logic [IDW-1:0] p);
        logic [IDW:0]   r;
        logic [IDW-1:0] ix;
        int             idx;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % N;
            ix  = IDW'(idx);
            if (v[ix]) begin
                r = {1'b1, ix};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_err_q, rsp_err_d;
    logic [I*L-1:0] rsp_data_q, rsp_data_d;

    logic           can_issue_s;
    logic [IDW:0]   pick_s;
    logic           grant_s;
    logic [IDW-1:0] winner_s;
    logic [4:0]     addr_s;
    logic           illegal_s;

    // Arbitration: choose the winner and drive the grant and mux select.
    // Grants are suppressed during reset and while a held response is stalled.
    always_comb begin
        can_issue_s = (state_q == ST_IDLE) | rsp_ready;
        pick_s      = rr_pick(req_valid, ptr_q);
        winner_s    = pick_s[IDW-1:0];
        grant_s     = ~rst & can_issue_s & pick_s[IDW];
        addr_s      = req_addr[int'(winner_s)*5 +: 5];
        // Legal window is 5'b10000..5'b10111.
        illegal_s   = (addr_s[4:3] != 2'b10);
        if (grant_s) begin
            req_ready = {{(N-1){1'b0}}, 1'b1} << winner_s;
            rf_sel    = addr_s;
        end else begin
            req_ready = '0;
            rf_sel    = 5'b00000;
        end
    end

    // Next-state logic: capture on a grant, retire on drain, otherwise hold.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        if (grant_s) begin
            // A grant in HOLD implies the consumer drains this same edge,
            // so the new response simply replaces the old one.
            state_d     = ST_HOLD;
            rsp_valid_d = 1'b1;
            rsp_id_d    = winner_s;
            rsp_err_d   = illegal_s;
            rsp_data_d  = illegal_s ? '0 : rf_data;
            ptr_d       = (int'(winner_s) == N - 1) ? '0 : IDW'(int'(winner_s) + 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        // Payload fields keep their last values after drain.
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b0;
                    end else begin
                        state_d     = ST_HOLD;
                        rsp_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and response registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_vreg_rd_arbiter.sv
// Directed, table-driven bench for vreg_rd_arbiter (N=4, 20 lanes x 8 bits).
// The mux is modelled by a fixed per-address lane pattern.
module tb_vreg_rd_arbiter;

    localparam int N   = 4;
    localparam int I   = 20;
    localparam int L   = 8;
    localparam int IDW = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*5-1:0] req_addr;
    logic [N-1:0]   req_ready;
    logic [4:0]     rf_sel;
    logic [I*L-1:0] rf_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic           rsp_err;
    logic [I*L-1:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    vreg_rd_arbiter #(.N(N), .I(I), .L(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rf_sel    (rf_sel),
        .rf_data   (rf_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file mux model: distinct, nonzero lane pattern per address.
    function automatic logic [I*L-1:0] pat(input logic [4:0] a);
        logic [I*L-1:0] d;
        for (int i = 0; i < I; i++) begin
            d[i*L +: L] = 8'(int'(a) * 7 + i * 13 + 1);
        end
        return d;
    endfunction

    assign rf_data = pat(rf_sel);

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [19:0] addrs;
        logic        rdy;
        logic [3:0]  e_rr;
        logic [4:0]  e_sel;
        logic        e_v;
        logic [1:0]  e_id;
        logic        e_err;
        logic        e_dz;
        logic [4:0]  e_daddr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [19:0] a,
                                input logic rd, input logic [3:0] err_rr, input logic [4:0] es,
                                input logic ev, input logic [1:0] eid, input logic ee,
                                input logic edz, input logic [4:0] eda);
        vec_t t;
        t.rst = r; t.vld = v; t.addrs = a; t.rdy = rd;
        t.e_rr = err_rr; t.e_sel = es; t.e_v = ev; t.e_id = eid;
        t.e_err = ee; t.e_dz = edz; t.e_daddr = eda;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    localparam logic [19:0] AD  = {5'd19, 5'd18, 5'd17, 5'd16};
    localparam logic [19:0] A2  = {5'd19, 5'd19, 5'd17, 5'd16};
    localparam logic [19:0] A3  = {5'd19, 5'd18, 5'd17, 5'd3};
    localparam logic [19:0] A24 = {5'd19, 5'd18, 5'd17, 5'd24};
    localparam logic [19:0] A23 = {5'd19, 5'd18, 5'd23, 5'd16};
    localparam logic [3:0]  F   = 4'b1111;
    localparam logic [3:0]  Z   = 4'b0000;

    vec_t vecs[35];

    initial begin
        logic [I*L-1:0] exp_data;
        logic [3:0]     one_hot;

        //              rst   vld      addrs rdy  e_rr     sel   v     id     err   dz    daddr
        vecs[0]  = mk(1'b1, F,       AD,  1'b1, Z,       5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 5'd0);
        vecs[1]  = mk(1'b0, Z,       AD,  1'b1, Z,       5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 5'd0);
        vecs[2]  = mk(1'b0, 4'b0100, A2,  1'b1, 4'b0100, 5'd19, 1'b1, 2'd2, 1'b0, 1'b0, 5'd19);
        vecs[3]  = mk(1'b0, Z,       AD,  1'b1, Z,       5'd0,  1'b0, 2'd2, 1'b0, 1'b0, 5'd19);
        vecs[4]  = mk(1'b1, F,       AD,  1'b1, Z,       5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 5'd0);
        vecs[5]  = mk(1'b0, F,       AD,  1'b1, 4'b0001, 5'd16, 1'b1, 2'd0, 1'b0, 1'b0, 5'd16);
        vecs[6]  = mk(1'b0, F,       AD,  1'b1, 4'b0010, 5'd17, 1'b1, 2'd1, 1'b0, 1'b0, 5'd17);
        vecs[7]  = mk(1'b0, F,       AD,  1'b1, 4'b0100, 5'd18, 1'b1, 2'd2, 1'b0, 1'b0, 5'd18);
        vecs[8]  = mk(1'b0, F,       AD,  1'b1, 4'b1000, 5'd19, 1'b1, 2'd3, 1'b0, 1'b0, 5'd19);
        vecs[9]  = mk(1'b0, F,       AD,  1'b1, 4'b0001, 5'd16, 1'b1, 2'd0, 1'b0, 1'b0, 5'd16);
        vecs[10] = mk(1'b0, F,       AD,  1'b1, 4'b0010, 5'd17, 1'b1, 2'd1, 1'b0, 1'b0, 5'd17);
        vecs[11] = mk(1'b1, F,       AD,  1'b0, Z,       5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 5'd0);
        vecs[12] = mk(1'b0, F,       AD,  1'b1, 4'b0001, 5'd16, 1'b1, 2'd0, 1'b0, 1'b0, 5'd16);
        vecs[13] = mk(1'b0, F,       AD,  1'b0, Z,       5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 5'd16);
        vecs[14] = mk(1'b0, F,       AD,  1'b0, Z,       5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 5'd16);
        vecs[15] = mk(1'b0, F,       AD,  1'b0, Z,       5'd0,  1'b1, 2'd0, 1'b0, 1'b0, 5'd16);
        vecs[16] = mk(1'b0, F,       AD,  1'b1, 4'b0010, 5'd17, 1'b1, 2'd1, 1'b0, 1'b0, 5'd17);
        vecs[17] = mk(1'b0, Z,       AD,  1'b1, Z,       5'd0,  1'b0, 2'd1, 1'b0, 1'b0, 5'd17);
        vecs[18] = mk(1'b1, Z,       AD,  1'b1, Z,       5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 5'd0);
        vecs[19] = mk(1'b0, 4'b0001, A3,  1'b1, 4'b0001, 5'd3,  1'b1, 2'd0, 1'b1, 1'b1, 5'd0);
        vecs[20] = mk(1'b0, F,       AD,  1'b1, 4'b0010, 5'd17, 1'b1, 2'd1, 1'b0, 1'b0, 5'd17);
        vecs[21] = mk(1'b1, Z,       AD,  1'b1, Z,       5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 5'd0);
        vecs[22] = mk(1'b0, 4'b1010, AD,  1'b1, 4'b0010, 5'd17, 1'b1, 2'd1, 1'b0, 1'b0, 5'd17);
        vecs[23] = mk(1'b0, 4'b1010, AD,  1'b1, 4'b1000, 5'd19, 1'b1, 2'd3, 1'b0, 1'b0, 5'd19);
        vecs[24] = mk(1'b0, 4'b1010, AD,  1'b1, 4'b0010, 5'd17, 1'b1, 2'd1, 1'b0, 1'b0, 5'd17);
        vecs[25] = mk(1'b0, 4'b1010, AD,  1'b1, 4'b1000, 5'd19, 1'b1, 2'd3, 1'b0, 1'b0, 5'd19);
        vecs[26] = mk(1'b0, Z,       AD,  1'b0, Z,       5'd0,  1'b1, 2'd3, 1'b0, 1'b0, 5'd19);
        vecs[27] = mk(1'b0, Z,       AD,  1'b0, Z,       5'd0,  1'b1, 2'd3, 1'b0, 1'b0, 5'd19);
        vecs[28] = mk(1'b1, 4'b1100, AD,  1'b0, Z,       5'd0,  1'b0, 2'd0, 1'b0, 1'b1, 5'd0);
        vecs[29] = mk(1'b0, 4'b1100, AD,  1'b1, 4'b0100, 5'd18, 1'b1, 2'd2, 1'b0, 1'b0, 5'd18);
        vecs[30] = mk(1'b0, 4'b1100, AD,  1'b1, 4'b1000, 5'd19, 1'b1, 2'd3, 1'b0, 1'b0, 5'd19);
        vecs[31] = mk(1'b0, 4'b1100, AD,  1'b1, 4'b0100, 5'd18, 1'b1, 2'd2, 1'b0, 1'b0, 5'd18);
        vecs[32] = mk(1'b0, 4'b0001, A24, 1'b1, 4'b0001, 5'd24, 1'b1, 2'd0, 1'b1, 1'b1, 5'd0);
        vecs[33] = mk(1'b0, 4'b0010, A23, 1'b1, 4'b0010, 5'd23, 1'b1, 2'd1, 1'b0, 1'b0, 5'd23);
        vecs[34] = mk(1'b0, Z,       AD,  1'b1, Z,       5'd0,  1'b0, 2'd1, 1'b0, 1'b0, 5'd23);

        rst       = 1'b1;
        req_valid = '0;
        req_addr  = AD;
        rsp_ready = 1'b1;

        // Table: inputs applied mid-cycle, grant/select checked before the edge,
        // registered response checked 1 time unit after the edge.
        for (int r = 0; r < 35; r++) begin
            rst       = vecs[r].rst;
            req_valid = vecs[r].vld;
            req_addr  = vecs[r].addrs;
            rsp_ready = vecs[r].rdy;
            #2;
            chk($sformatf("row%0d req_ready", r), 160'(req_ready), 160'(vecs[r].e_rr));
            chk($sformatf("row%0d rf_sel", r),    160'(rf_sel),    160'(vecs[r].e_sel));
            @(posedge clk);
            #1;
            exp_data = vecs[r].e_dz ? '0 : pat(vecs[r].e_daddr);
            chk($sformatf("row%0d rsp_valid", r), 160'(rsp_valid), 160'(vecs[r].e_v));
            chk($sformatf("row%0d rsp_id", r),    160'(rsp_id),    160'(vecs[r].e_id));
            chk($sformatf("row%0d rsp_err", r),   160'(rsp_err),   160'(vecs[r].e_err));
            chk($sformatf("row%0d rsp_data", r),  rsp_data,        exp_data);
        end

        // Sustained throughput: after reset, all requesters valid and the
        // consumer always ready gives one grant per cycle in strict rotation.
        rst       = 1'b1;
        req_valid = F;
        req_addr  = AD;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            one_hot = 4'b0001 << (k % 4);
            #2;
            chk($sformatf("tput%0d req_ready", k), 160'(req_ready), 160'(one_hot));
            @(posedge clk);
            #1;
            chk($sformatf("tput%0d rsp_valid", k), 160'(rsp_valid), 160'(1'b1));
            chk($sformatf("tput%0d rsp_id", k),    160'(rsp_id),    160'(k % 4));
            chk($sformatf("tput%0d rsp_data", k),  rsp_data,        pat(5'(16 + (k % 4))));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
